// File: rtl/nios2_system_char_rx_pkg.sv
// Shared definitions for the character receive controller: register map,
// STATUS bit layout and receive FSM state encoding.
package nios2_system_char_rx_pkg;

  localparam logic [1:0] ADDR_DATA   = 2'd0;
  localparam logic [1:0] ADDR_STATUS = 2'd1;
  localparam logic [1:0] ADDR_CTRL   = 2'd2;
  localparam logic [1:0] ADDR_CLEAR  = 2'd3;

  localparam int STAT_NOT_EMPTY = 0;
  localparam int STAT_OVR       = 1;
  localparam int STAT_FERR      = 2;
  localparam int STAT_BUSY      = 3;
  localparam int STAT_COUNT_LSB = 4;
  localparam int STAT_COUNT_W   = 3;

  localparam int CTRL_IRQ_EN = 0;
  localparam int CTRL_RX_EN  = 1;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_HIGH = 3'd4
  } rx_state_t;

endpackage

// File: rtl/nios2_system_char_rx_ctrl_if.sv
// Avalon-MM slave bus bundle for the receive controller register file.
interface nios2_system_char_rx_ctrl_if;
  logic [1:0]  address;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (output address, output read, output write,
                  output writedata, input readdata);
  modport slave  (input address, input read, input write,
                  input writedata, output readdata);
endinterface

// File: rtl/nios2_system_char_rx_fifo.sv
// Small synchronous FIFO for received bytes. A push while full is accepted
// only when a pop happens in the same cycle (the pop frees the slot).
module nios2_system_char_rx_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [DATA_W-1:0]        i_wdata,
  output logic [DATA_W-1:0]        o_rdata,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);
  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW:0]       r_wr_ptr;
  logic [AW:0]       r_rd_ptr;
  logic              w_do_push;
  logic              w_do_pop;

  assign o_count   = r_wr_ptr - r_rd_ptr;
  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (o_count == (AW+1)'(DEPTH));
  assign o_rdata   = r_mem[r_rd_ptr[AW-1:0]];
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);

  // Storage array; contents are meaningless until pointed at, so no reset.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
  end

  // Read/write pointers; one extra bit distinguishes full from empty.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
    end
  end
endmodule

// File: rtl/nios2_system_char_rx_ctrl.sv
// 8N1 serial receiver with a byte FIFO and an Avalon-MM register file
// (DATA / STATUS / CONTROL / CLEAR) plus a level interrupt.
module nios2_system_char_rx_ctrl
  import nios2_system_char_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                        clk,
  input  logic                        reset_n,
  nios2_system_char_rx_ctrl_if.slave  bus,
  input  logic                        rx_serial,
  output logic                        irq
);
  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0] HALF_TICK = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] LAST_TICK = TW'(CLKS_PER_BIT - 1);

  logic                      r_sync1, r_sync2;
  rx_state_t                 r_state;
  logic [TW-1:0]             r_timer;
  logic [2:0]                r_bitcnt;
  logic [7:0]                r_shift;
  logic                      r_irq_en, r_rx_en, r_ovr, r_ferr;
  logic                      w_sample_stop, w_push, w_ferr_set, w_ovr_set;
  logic                      w_pop, w_wr_clear, w_wr_ctrl;
  logic                      w_full, w_empty;
  logic [7:0]                w_head;
  logic [$clog2(FIFO_DEPTH):0] w_count;
  logic [31:0]               w_status;
  logic                      w_unused_wdata;

  assign w_sample_stop = r_rx_en && (r_state == STOP) && (r_timer == LAST_TICK);
  assign w_push        = w_sample_stop && r_sync2;
  assign w_ferr_set    = w_sample_stop && !r_sync2;
  assign w_pop         = bus.read && (bus.address == ADDR_DATA) && !w_empty;
  assign w_ovr_set     = w_push && w_full && !w_pop;
  assign w_wr_clear    = bus.write && (bus.address == ADDR_CLEAR);
  assign w_wr_ctrl     = bus.write && (bus.address == ADDR_CTRL);
  assign irq           = r_irq_en && (!w_empty || r_ovr || r_ferr);
  assign w_unused_wdata = ^bus.writedata[31:3];

  // Two-flop synchronizer for the asynchronous line, reset to idle-high.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= rx_serial;
      r_sync2 <= r_sync1;
    end
  end

  // Receive FSM and bit timer; dropping rx_en aborts any frame in progress.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= IDLE;
      r_timer  <= '0;
      r_bitcnt <= '0;
    end else if (!r_rx_en) begin
      r_state  <= IDLE;
      r_timer  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_timer <= '0;
          if (!r_sync2) r_state <= START;
        end
        START: begin
          if (r_timer == HALF_TICK) begin
            r_timer  <= '0;
            r_bitcnt <= '0;
            r_state  <= r_sync2 ? IDLE : DATA;
          end else begin
            r_timer <= r_timer + TW'(1);
          end
        end
        DATA: begin
          if (r_timer == LAST_TICK) begin
            r_timer  <= '0;
            r_bitcnt <= r_bitcnt + 3'd1;
            if (r_bitcnt == 3'd7) r_state <= STOP;
          end else begin
            r_timer <= r_timer + TW'(1);
          end
        end
        STOP: begin
          if (r_timer == LAST_TICK) begin
            r_timer <= '0;
            r_state <= r_sync2 ? IDLE : WAIT_HIGH;
          end else begin
            r_timer <= r_timer + TW'(1);
          end
        end
        WAIT_HIGH: begin
          if (r_sync2) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Data bits arrive LSB first, so shift in from the top.
  always_ff @(posedge clk) begin
    if (r_state == DATA && r_timer == LAST_TICK) r_shift <= {r_sync2, r_shift[7:1]};
  end

  // Control and sticky error flags; a set in the same cycle as a clear wins.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_irq_en <= 1'b0;
      r_rx_en  <= 1'b0;
      r_ovr    <= 1'b0;
      r_ferr   <= 1'b0;
    end else begin
      if (w_wr_ctrl) begin
        r_irq_en <= bus.writedata[CTRL_IRQ_EN];
        r_rx_en  <= bus.writedata[CTRL_RX_EN];
      end
      r_ovr  <= w_ovr_set  | (r_ovr  & ~(w_wr_clear & bus.writedata[STAT_OVR]));
      r_ferr <= w_ferr_set | (r_ferr & ~(w_wr_clear & bus.writedata[STAT_FERR]));
    end
  end

  // STATUS word assembled from live state.
  always_comb begin
    w_status = '0;
    w_status[STAT_NOT_EMPTY] = !w_empty;
    w_status[STAT_OVR]       = r_ovr;
    w_status[STAT_FERR]      = r_ferr;
    w_status[STAT_BUSY]      = (r_state != IDLE);
    w_status[STAT_COUNT_LSB +: STAT_COUNT_W] = STAT_COUNT_W'(w_count);
  end

  // Registered read data, held until the next read strobe.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.readdata <= '0;
    end else if (bus.read) begin
      case (bus.address)
        ADDR_DATA:   bus.readdata <= w_empty ? 32'd0 : {24'd0, w_head};
        ADDR_STATUS: bus.readdata <= w_status;
        ADDR_CTRL:   bus.readdata <= {30'd0, r_rx_en, r_irq_en};
        default:     bus.readdata <= 32'd0;
      endcase
    end
  end

  nios2_system_char_rx_fifo #(
    .DATA_W (8),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_wdata (r_shift),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );
endmodule

// File: tb/tb_nios2_system_char_rx_ctrl.sv
// Directed bench for the character receive controller at CLKS_PER_BIT=8.
module tb_nios2_system_char_rx_ctrl;
  import nios2_system_char_rx_pkg::*;

  localparam int CPB = 8;

  logic clk;
  logic reset_n;
  logic rx_serial;
  logic irq;
  int   n_cmp;
  int   n_err;
  logic [31:0] rd;
  logic [31:0] rd_pop;

  nios2_system_char_rx_ctrl_if bus();

  nios2_system_char_rx_ctrl #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (4)
  ) u_dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .bus       (bus),
    .rx_serial (rx_serial),
    .irq       (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [1:0] addr, input logic [31:0] data);
    bus.address   = addr;
    bus.writedata = data;
    bus.write     = 1'b1;
    tick(1);
    bus.write     = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] addr, output logic [31:0] data);
    bus.address = addr;
    bus.read    = 1'b1;
    tick(1);
    bus.read    = 1'b0;
    data        = bus.readdata;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    rx_serial = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      rx_serial = b[i];
      tick(CPB);
    end
    rx_serial = stop_bit;
    tick(CPB);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset_n = 1'b0;
    rx_serial = 1'b1;
    bus.address = 2'd0;
    bus.read = 1'b0;
    bus.write = 1'b0;
    bus.writedata = 32'd0;
    tick(3);
    reset_n = 1'b1;
    tick(2);

    // Reset state
    check("reset_readdata", bus.readdata, 32'h0);
    check("reset_irq", {31'd0, irq}, 32'h0);
    bus_read(ADDR_STATUS, rd);
    check("reset_status", rd, 32'h00);

    // Basic frame 0x41
    bus_write(ADDR_CTRL, 32'h3);
    bus_read(ADDR_CTRL, rd);
    check("ctrl_readback", rd, 32'h3);
    send_byte(8'h41, 1'b1);
    bus_read(ADDR_STATUS, rd);
    check("f41_status", rd, 32'h11);
    check("f41_irq", {31'd0, irq}, 32'h1);
    bus_read(ADDR_DATA, rd);
    check("f41_data", rd, 32'h41);
    bus_read(ADDR_STATUS, rd);
    check("f41_status_after", rd, 32'h00);
    check("f41_irq_after", {31'd0, irq}, 32'h0);
    bus_read(ADDR_CLEAR, rd);
    check("clear_reads_zero", rd, 32'h0);

    // Two-cycle low glitch on idle line
    rx_serial = 1'b0;
    tick(2);
    rx_serial = 1'b1;
    tick(1);
    bus_read(ADDR_STATUS, rd);
    check("glitch_busy", rd, 32'h08);
    tick(10);
    bus_read(ADDR_STATUS, rd);
    check("glitch_status", rd, 32'h00);

    // Receiver disabled: frame ignored
    bus_write(ADDR_CTRL, 32'h1);
    send_byte(8'h5A, 1'b1);
    bus_read(ADDR_STATUS, rd);
    check("rxdis_status", rd, 32'h00);
    bus_write(ADDR_CTRL, 32'h3);

    // Five frames without reads: overrun
    for (int i = 1; i <= 5; i++) send_byte(8'(i), 1'b1);
    bus_read(ADDR_STATUS, rd);
    check("ovr_status", rd, 32'h43);
    check("ovr_irq", {31'd0, irq}, 32'h1);
    bus_read(ADDR_DATA, rd);
    check("ovr_data1", rd, 32'h01);
    bus_read(ADDR_DATA, rd);
    check("ovr_data2", rd, 32'h02);
    bus_read(ADDR_DATA, rd);
    check("ovr_data3", rd, 32'h03);
    bus_read(ADDR_DATA, rd);
    check("ovr_data4", rd, 32'h04);
    bus_read(ADDR_DATA, rd);
    check("empty_read", rd, 32'h00);
    bus_read(ADDR_STATUS, rd);
    check("ovr_status_empty", rd, 32'h02);
    bus_write(ADDR_CLEAR, 32'h2);
    bus_read(ADDR_STATUS, rd);
    check("ovr_cleared", rd, 32'h00);

    // Framing error with line held low
    send_byte(8'h55, 1'b0);
    bus_read(ADDR_STATUS, rd);
    check("ferr_status_low", rd, 32'h0C);
    check("ferr_irq", {31'd0, irq}, 32'h1);
    rx_serial = 1'b1;
    tick(4);
    bus_read(ADDR_STATUS, rd);
    check("ferr_status_high", rd, 32'h04);
    bus_write(ADDR_CLEAR, 32'h4);
    bus_read(ADDR_STATUS, rd);
    check("ferr_cleared", rd, 32'h00);

    // Full FIFO, DATA read on the exact push cycle of the fifth frame
    for (int i = 0; i < 4; i++) send_byte(8'h11 + 8'(i), 1'b1);
    bus_read(ADDR_STATUS, rd);
    check("full_status", rd, 32'h41);
    fork
      send_byte(8'h15, 1'b1);
      begin
        repeat (9 * CPB + 6) @(posedge clk);
        #1;
        bus_read(ADDR_DATA, rd_pop);
      end
    join
    check("pushpop_data", rd_pop, 32'h11);
    bus_read(ADDR_STATUS, rd);
    check("pushpop_status", rd, 32'h41);
    bus_read(ADDR_DATA, rd);
    check("pushpop_d2", rd, 32'h12);
    bus_read(ADDR_DATA, rd);
    check("pushpop_d3", rd, 32'h13);
    bus_read(ADDR_DATA, rd);
    check("pushpop_d4", rd, 32'h14);
    bus_read(ADDR_DATA, rd);
    check("pushpop_d5", rd, 32'h15);

    // Reset mid-frame with two bytes buffered
    send_byte(8'h21, 1'b1);
    send_byte(8'h22, 1'b1);
    bus_read(ADDR_STATUS, rd);
    check("pre_reset_status", rd, 32'h21);
    rx_serial = 1'b0;
    tick(30);
    reset_n = 1'b0;
    tick(2);
    check("midreset_readdata", bus.readdata, 32'h0);
    check("midreset_irq", {31'd0, irq}, 32'h0);
    rx_serial = 1'b1;
    reset_n = 1'b1;
    tick(2);
    bus_read(ADDR_STATUS, rd);
    check("post_reset_status", rd, 32'h00);
    bus_read(ADDR_CTRL, rd);
    check("post_reset_ctrl", rd, 32'h0);
    bus_write(ADDR_CTRL, 32'h3);
    send_byte(8'h7E, 1'b1);
    bus_read(ADDR_STATUS, rd);
    check("f7e_status", rd, 32'h11);
    bus_read(ADDR_DATA, rd);
    check("f7e_data", rd, 32'h7E);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/nios2_system_char_rx_ctrl.md
# nios2_system_char_rx_ctrl

Character receive controller for the Nios II system: samples a serial 8N1 RX line, assembles bytes, and buffers them in a 4-entry FIFO. Software reads the bytes through an Avalon-MM slave with data, status and control registers, and can take an optional interrupt. It replaces raw polling of a 1-bit input port with a sequenced, buffered receive path for the link between game boards.

## Interface
- CLKS_PER_BIT, 434, clk cycles per serial bit (50 MHz / 115200); must be ≥ 4.
- FIFO_DEPTH, 4, receive buffer entries; must be a power of 2.
- clk  in  1  system clock; every register updates on its rising edge.
- reset_n  in  1  reset; one clock; reset is asynchronous and active-low.
- address  in  2  register select: 0 DATA, 1 STATUS, 2 CONTROL, 3 CLEAR.
- read  in  1  Avalon read strobe, one cycle per access.
- write  in  1  Avalon write strobe, one cycle per access.
- writedata  in  32  write data.
- rx_serial  in  1  asynchronous serial line; idles high.
- readdata  out  32  registered read data.
- irq  out  1  level interrupt request.

## Operation
- rx_serial passes through a 2-flop synchronizer; the FSM sees only the synchronized bit.
- FSM states and transitions:
  - IDLE: a synchronized low starts a bit timer, go to START.
  - START: at CLKS_PER_BIT/2 (integer divide) the line is sampled. Low: go to DATA. High: glitch, back to IDLE, nothing logged.
  - DATA: every CLKS_PER_BIT cycles one bit is sampled, LSB first, into a shift register. After 8 bits, go to STOP.
  - STOP: one CLKS_PER_BIT later the line is sampled.
    - High: push the byte and go to IDLE.
    - Low: set ferr, drop the byte, go to WAIT_HIGH.
  - WAIT_HIGH: the first synchronized high returns the FSM to IDLE.
- CONTROL register: bit0 irq_en, bit1 rx_en. Both reset to 0.
  - rx_en=0 holds the FSM in IDLE.
  - Clearing rx_en mid-frame aborts the frame immediately with no push and no flag.
- A push while the FIFO is full drops the byte and sets ovr. FIFO contents are unchanged.
- DATA read returns {24'b0, head byte} and pops one entry.
  - Reading an empty FIFO returns 0 and does not pop; the count never underflows.
- STATUS read returns:
  - bit0 not_empty
  - bit1 ovr
  - bit2 ferr
  - bit3 busy (FSM not IDLE)
  - bits[6:4] count (0..4)
  - all other bits 0
- Reading CONTROL returns its value. Reading CLEAR returns 0.
- Writing CLEAR with writedata bit1 clears ovr; bit2 clears ferr. Writes to DATA and STATUS are ignored.
- Push and pop in the same cycle:
  - count unchanged, both operations succeed, even when full. The pop frees the slot, so no ovr is set.
  - When empty, the pop is ignored and the push succeeds.
- Flag set and CLEAR write in the same cycle: set wins, the flag stays 1.
- irq = irq_en & (not_empty | ovr | ferr). It is combinational from registered state.

## Timing
- Reset values:
  - readdata 0, irq 0, FSM IDLE, FIFO empty.
  - ovr, ferr, irq_en and rx_en all 0.
  - Synchronizer flops reset to 1 (line idle).
- Read latency is 1 cycle: readdata is valid the cycle after read and holds until the next read. Read wait states are 0.
- Writes take effect on the strobe edge.
- A DATA pop takes effect at the strobe edge. A STATUS read in the following cycle reflects the new count.
- End-to-end latency: from the synchronized mid-stop-bit sample to not_empty=1 is 1 cycle. Add 2 cycles of synchronizer delay from the pin.
- Reset asserted mid-frame discards the partial byte and FIFO contents and returns all state to reset values. After reset the first falling edge starts a fresh frame.

## Structure
- Shared package nios2_system_char_rx_pkg holds:
  - register offsets ADDR_DATA=0, ADDR_STATUS=1, ADDR_CTRL=2, ADDR_CLEAR=3
  - the STATUS bit positions
  - the FSM state enum {IDLE, START, DATA, STOP, WAIT_HIGH}
- Sub-module nios2_system_char_rx_fifo: synchronous FIFO with push, pop, full, empty and count outputs. Same clock and reset as the parent.
- The FSM, bit timer, synchronizer and register file live in the top module.

## Test plan
- Reset, then CONTROL=0x3 and serial frame 0x41 at CLKS_PER_BIT=8 -> STATUS=0x11; irq=1; DATA read returns 0x41; next STATUS=0x00; irq=0.
- Low glitch of 2 cycles on an idle line (CLKS_PER_BIT=8) -> FSM returns to IDLE; STATUS=0x00; no push.
- Five frames 0x01..0x05 with no reads -> STATUS=0x43 (count 4, ovr); reads return 0x01,0x02,0x03,0x04, then a 5th read returns 0; writing CLEAR=0x2 clears ovr.
- Frame 0x55 with the stop bit low -> ferr=1; count 0; the line held low keeps busy=1 until it goes high; CLEAR=0x4 clears ferr.
- FIFO full (4 entries) and a DATA read on the exact cycle of the 5th push -> ovr stays 0; count stays 4; the first read returns the oldest byte.
- reset_n pulsed low mid-DATA-bit with 2 bytes buffered -> all outputs 0 and FIFO empty; a subsequent frame 0x7E is received correctly.
